// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - shared encodings for the multicycle main controller
// Purpose: state codes, ALU/EXT/NPC/select encodings, MIPS-subset op/funct
//          values and the instruction class enum used by controller and decoder.
// Ports: none (package).
package mc_ctrl_fsm_pkg;

  // FSM state codes
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXE_R   = 4'd2;
  localparam logic [3:0] S_EXE_I   = 4'd3;
  localparam logic [3:0] S_ALU_WB  = 4'd4;
  localparam logic [3:0] S_MEM_ADR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WB  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_HALT    = 4'd11;

  // ALU operation codes
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  // Immediate extender modes
  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  // Next-PC selects
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  // Destination register and write-data selects
  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_RA  = 2'd2;
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DM   = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2a;

  typedef enum logic [3:0] {
    CLS_R_ALU,
    CLS_I_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILL
  } instr_cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational op/funct decoder for the main controller
// Purpose: classify an instruction and derive its ALU operation and extender mode.
// Ports:
//   op_i      in  6  opcode IR[31:26]
//   funct_i   in  6  function field IR[5:0]
//   cls_o     out    instruction class
//   alu_op_o  out 4  ALU operation for the execute/branch step
//   ext_op_o  out 2  immediate extender mode
//   illegal_o out 1  op/funct not in the supported subset
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_cls_e cls_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] ext_op_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o    = CLS_ILL;
    alu_op_o = ALU_NOP;
    ext_op_o = EXT_ZERO;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADDU: begin cls_o = CLS_R_ALU; alu_op_o = ALU_ADD; end
          F_SUBU: begin cls_o = CLS_R_ALU; alu_op_o = ALU_SUB; end
          F_AND:  begin cls_o = CLS_R_ALU; alu_op_o = ALU_AND; end
          F_OR:   begin cls_o = CLS_R_ALU; alu_op_o = ALU_OR;  end
          F_SLT:  begin cls_o = CLS_R_ALU; alu_op_o = ALU_SLT; end
          F_SLL:  begin cls_o = CLS_R_ALU; alu_op_o = ALU_SLL; end
          F_SRL:  begin cls_o = CLS_R_ALU; alu_op_o = ALU_SRL; end
          F_JR:   cls_o = CLS_JR;
          default: cls_o = CLS_ILL;
        endcase
      end
      OP_J:     cls_o = CLS_J;
      OP_JAL:   cls_o = CLS_JAL;
      OP_BEQ:   begin cls_o = CLS_BEQ;   alu_op_o = ALU_SUB; ext_op_o = EXT_SIGNED; end
      OP_BNE:   begin cls_o = CLS_BNE;   alu_op_o = ALU_SUB; ext_op_o = EXT_SIGNED; end
      OP_ADDI:  begin cls_o = CLS_I_ALU; alu_op_o = ALU_ADD; ext_op_o = EXT_SIGNED; end
      OP_ADDIU: begin cls_o = CLS_I_ALU; alu_op_o = ALU_ADD; ext_op_o = EXT_SIGNED; end
      OP_ANDI:  begin cls_o = CLS_I_ALU; alu_op_o = ALU_AND; ext_op_o = EXT_ZERO;   end
      OP_ORI:   begin cls_o = CLS_I_ALU; alu_op_o = ALU_OR;  ext_op_o = EXT_ZERO;   end
      // rs is $0 for lui, so an add passes the shifted immediate straight through
      OP_LUI:   begin cls_o = CLS_I_ALU; alu_op_o = ALU_ADD; ext_op_o = EXT_HIGHPOS; end
      OP_LW:    begin cls_o = CLS_LW;    alu_op_o = ALU_ADD; ext_op_o = EXT_SIGNED; end
      OP_SW:    begin cls_o = CLS_SW;    alu_op_o = ALU_ADD; ext_op_o = EXT_SIGNED; end
      default:  cls_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CLS_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle main controller for the MIPS-subset datapath
// Purpose: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK (3-5 cycles per
//          instruction) and drives every datapath select and write enable.
// Ports:
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset
//   op      in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   zero    in  1  ALU zero flag, used in S_BRANCH
//   PCWr    out 1  PC write enable
//   IRWr    out 1  IR write enable
//   RFWr    out 1  register file write enable
//   DMWr    out 1  data memory write enable
//   EXTOp   out 2  immediate extender mode
//   ALUOp   out 4  ALU operation
//   ALUSrcB out 1  0 rt data, 1 Imm32
//   GPRSel  out 2  destination: 0 rd, 1 rt, 2 $31
//   WDSel   out 2  RF write data: 0 ALU, 1 DM, 2 PC+4
//   NPCOp   out 2  0 PC+4, 1 branch, 2 jump, 3 jr
//   illegal out 1  high while halted on an unsupported instruction
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter logic ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] EXTOp,
  output logic [3:0] ALUOp,
  output logic       ALUSrcB,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       illegal
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, funct_q;
  logic [5:0] dec_op, dec_funct;

  instr_cls_e dec_cls;
  logic [3:0] dec_alu;
  logic [1:0] dec_ext;
  logic       dec_illegal;

  // IR was written at the end of FETCH, so during DECODE the live fields are
  // already the current instruction; afterwards the latched copy is used.
  assign dec_op    = (state_q == S_DECODE) ? op    : op_q;
  assign dec_funct = (state_q == S_DECODE) ? funct : funct_q;

  mc_ctrl_decode u_decode (
    .op_i      (dec_op),
    .funct_i   (dec_funct),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu),
    .ext_op_o  (dec_ext),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q    <= op;
        funct_q <= funct;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        end else begin
          case (dec_cls)
            CLS_J, CLS_JAL, CLS_JR: state_d = S_JUMP;
            CLS_BEQ, CLS_BNE:       state_d = S_BRANCH;
            CLS_LW, CLS_SW:         state_d = S_MEM_ADR;
            CLS_R_ALU:              state_d = S_EXE_R;
            CLS_I_ALU:              state_d = S_EXE_I;
            default:                state_d = S_FETCH;
          endcase
        end
      end
      S_EXE_R:   state_d = S_ALU_WB;
      S_EXE_I:   state_d = S_ALU_WB;
      S_ALU_WB:  state_d = S_FETCH;
      S_MEM_ADR: state_d = (dec_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WR:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while rst is high so that no
  // write enable escapes during the reset cycle itself.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    EXTOp   = EXT_ZERO;
    ALUOp   = ALU_NOP;
    ALUSrcB = 1'b0;
    GPRSel  = GPR_RD;
    WDSel   = WD_ALU;
    NPCOp   = NPC_PC4;
    illegal = 1'b0;
    if (!rst) begin
      // Extender mode follows the instruction from DECODE to its last state
      if (state_q != S_FETCH && state_q != S_HALT) begin
        EXTOp = dec_ext;
      end
      case (state_q)
        S_FETCH: begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
          NPCOp = NPC_PC4;
        end
        S_EXE_R: begin
          ALUSrcB = 1'b0;
          ALUOp   = dec_alu;
        end
        S_EXE_I: begin
          ALUSrcB = 1'b1;
          ALUOp   = dec_alu;
        end
        S_ALU_WB: begin
          RFWr   = 1'b1;
          WDSel  = WD_ALU;
          GPRSel = (dec_cls == CLS_R_ALU) ? GPR_RD : GPR_RT;
        end
        S_MEM_ADR: begin
          ALUSrcB = 1'b1;
          ALUOp   = ALU_ADD;
        end
        S_MEM_WB: begin
          RFWr   = 1'b1;
          GPRSel = GPR_RT;
          WDSel  = WD_DM;
        end
        S_MEM_WR: DMWr = 1'b1;
        S_BRANCH: begin
          ALUOp = ALU_SUB;
          NPCOp = NPC_BRANCH;
          PCWr  = (dec_cls == CLS_BEQ) ? zero : ~zero;
        end
        S_JUMP: begin
          PCWr  = 1'b1;
          NPCOp = (dec_cls == CLS_JR) ? NPC_JR : NPC_JUMP;
          if (dec_cls == CLS_JAL) begin
            RFWr   = 1'b1;
            GPRSel = GPR_RA;
            WDSel  = WD_PC4;
          end
        end
        S_HALT: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
